// File: rtl/audio_tone_writer.sv
// Square-wave tone burst generator feeding the audio codec write port through
// the write/write_ready handshake; left and right carry the same sample.
module audio_tone_writer #(
  parameter int DATA_W = 24,
  parameter int HALF_W = 16,
  parameter int LEN_W  = 20
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              start,
  input  logic [HALF_W-1:0] half_period,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [DATA_W-2:0] amplitude,
  input  logic              stop,
  input  logic              write_ready,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_NEXT
  } state_t;

  localparam logic [HALF_W-1:0] HALF_ONE = HALF_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  state_t              state_q, state_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-2:0]   amp_q, amp_d;
  logic [HALF_W-1:0]   phase_q, phase_d;
  logic [LEN_W-1:0]    sample_q, sample_d;
  logic                pos_q, pos_d;
  logic                stop_pend_q, stop_pend_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                write_q, write_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [HALF_W-1:0]   half_eff;
  logic [DATA_W-1:0]   amp_ext;
  logic                last_sample;

  assign half_eff    = (half_q == '0) ? HALF_ONE : half_q;
  assign amp_ext     = {1'b0, amp_q};
  assign last_sample = (len_q != '0) && ((sample_q + LEN_ONE) == len_q);

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    len_d       = len_q;
    amp_d       = amp_q;
    phase_d     = phase_q;
    sample_d    = sample_q;
    pos_d       = pos_q;
    stop_pend_d = stop_pend_q;
    data_d      = data_q;
    write_d     = (state_q == S_WRITE);
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        data_d      = '0;
        stop_pend_d = 1'b0;
        if (start) begin
          half_d   = half_period;
          len_d    = burst_len;
          amp_d    = amplitude;
          phase_d  = '0;
          sample_d = '0;
          pos_d    = 1'b1;
          data_d   = {1'b0, amplitude};
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          data_d  = '0;
        end else if (write_ready) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // Stop is only remembered here so the write in flight still lands.
        stop_pend_d = stop;
        state_d     = S_NEXT;
      end
      S_NEXT: begin
        sample_d = sample_q + LEN_ONE;
        if (phase_q == (half_eff - HALF_ONE)) begin
          phase_d = '0;
          pos_d   = ~pos_q;
        end else begin
          phase_d = phase_q + HALF_ONE;
        end
        data_d = pos_d ? amp_ext : -amp_ext;
        if (last_sample || stop_pend_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          data_d  = '0;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      half_q      <= '0;
      len_q       <= '0;
      amp_q       <= '0;
      phase_q     <= '0;
      sample_q    <= '0;
      pos_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      data_q      <= '0;
      write_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      len_q       <= len_d;
      amp_q       <= amp_d;
      phase_q     <= phase_d;
      sample_q    <= sample_d;
      pos_q       <= pos_d;
      stop_pend_q <= stop_pend_d;
      data_q      <= data_d;
      write_q     <= write_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign write           = write_q;
  assign done            = done_q;
  assign busy            = busy_q;
  assign writedata_left  = data_q;
  assign writedata_right = data_q;

endmodule

// File: tb/tb_audio_tone_writer.sv
// Directed bench for audio_tone_writer: bursts, backpressure, degenerate
// parameters, stop handling, busy lockout and asynchronous reset.
module tb_audio_tone_writer;

  logic        CLOCK_50;
  logic        resetn;
  logic        start;
  logic [15:0] half_period;
  logic [19:0] burst_len;
  logic [22:0] amplitude;
  logic        stop;
  logic        write_ready;
  logic        write;
  logic [23:0] writedata_left;
  logic [23:0] writedata_right;
  logic        busy;
  logic        done;

  audio_tone_writer dut (
    .CLOCK_50        (CLOCK_50),
    .resetn          (resetn),
    .start           (start),
    .half_period     (half_period),
    .burst_len       (burst_len),
    .amplitude       (amplitude),
    .stop            (stop),
    .write_ready     (write_ready),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .busy            (busy),
    .done            (done)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int          checks;
  int          failures;
  int          cyc;
  logic [23:0] wq[$];
  int          wc[$];
  int          dn_cnt;
  int          dn_cyc;
  int          lr_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Square wave reference: sample i is positive when floor(i/half) is even.
  function automatic logic [23:0] exp_sample(input logic [22:0] a, input int half, input int i);
    int          h;
    logic [23:0] m;
    h = (half == 0) ? 1 : half;
    m = {1'b0, a};
    return (((i / h) % 2) == 0) ? m : (24'd0 - m);
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    cyc++;
    if (write === 1'b1) begin
      wq.push_back(writedata_left);
      wc.push_back(cyc);
    end
    if (done === 1'b1) begin
      dn_cnt++;
      dn_cyc = cyc;
    end
    if (writedata_left !== writedata_right) lr_bad++;
  endtask

  task automatic clear_log();
    wq.delete();
    wc.delete();
    dn_cnt = 0;
    dn_cyc = -1;
    lr_bad = 0;
  endtask

  task automatic launch(input int h, input int len, input logic [22:0] a, output int c0);
    half_period = 16'(h);
    burst_len   = 20'(len);
    amplitude   = a;
    start       = 1'b1;
    tick();
    start = 1'b0;
    c0    = cyc;
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (wq.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (wq.size() < n) check({tag, "_timeout"}, 32'(wq.size()), 32'(n));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (dn_cnt == 0 && k < budget) begin
      tick();
      k++;
    end
    if (dn_cnt == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_seq(input string tag, input logic [22:0] a, input int h, input int n);
    check({tag, "_count"}, 32'(wq.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < wq.size()) check($sformatf("%s_data%0d", tag, i), 32'(wq[i]), 32'(exp_sample(a, h, i)));
    end
    check({tag, "_lr"}, 32'(lr_bad), 32'd0);
  endtask

  initial begin
    int c0;
    int bad;
    int nw;

    checks      = 0;
    failures    = 0;
    cyc         = 0;
    resetn      = 1'b0;
    start       = 1'b0;
    half_period = '0;
    burst_len   = '0;
    amplitude   = '0;
    stop        = 1'b0;
    write_ready = 1'b0;
    clear_log();

    tick();
    check("rst_write", 32'(write), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(writedata_left), 32'd0);
    #2 resetn = 1'b1;
    tick();

    // Basic burst: 8 writes three cycles apart, done one cycle after the last.
    write_ready = 1'b1;
    clear_log();
    launch(2, 8, 23'h000100, c0);
    check("basic_busy", 32'(busy), 32'd1);
    wait_done("basic", 100);
    check_seq("basic", 23'h000100, 2, 8);
    for (int i = 0; i < 8; i++) begin
      if (i < wc.size()) check($sformatf("basic_cyc%0d", i), 32'(wc[i] - c0), 32'(2 + 3 * i));
    end
    check("basic_done_cyc", 32'(dn_cyc - c0), 32'd24);
    check("basic_idle_busy", 32'(busy), 32'd0);
    check("basic_idle_data", 32'(writedata_left), 32'd0);
    repeat (5) tick();
    check("basic_done_once", 32'(dn_cnt), 32'd1);
    check("basic_no_extra", 32'(wq.size()), 32'd8);

    // Backpressure: pauses after the first and second writes; data must hold.
    clear_log();
    launch(2, 8, 23'h000100, c0);
    wait_writes("bp1", 1, 20);
    write_ready = 1'b0;
    tick();
    bad = 0;
    repeat (20) begin
      tick();
      if (writedata_left !== 24'h000100) bad++;
    end
    check("bp1_hold", 32'(bad), 32'd0);
    check("bp1_nowrite", 32'(wq.size()), 32'd1);
    write_ready = 1'b1;
    wait_writes("bp2", 2, 20);
    write_ready = 1'b0;
    tick();
    bad = 0;
    repeat (50) begin
      tick();
      if (writedata_left !== 24'hFFFF00) bad++;
    end
    check("bp2_hold", 32'(bad), 32'd0);
    check("bp2_nowrite", 32'(wq.size()), 32'd2);
    check("bp2_busy", 32'(busy), 32'd1);
    write_ready = 1'b1;
    wait_done("bp", 100);
    check_seq("bp", 23'h000100, 2, 8);
    check("bp_done", 32'(dn_cnt), 32'd1);

    // Degenerate values: half=0 flips every sample; full-scale and zero amplitude.
    clear_log();
    launch(0, 4, 23'h7FFFFF, c0);
    wait_done("deg_max", 60);
    check_seq("deg_max", 23'h7FFFFF, 0, 4);
    check("deg_max_neg", 32'(wq[1]), 32'h800001);
    clear_log();
    launch(0, 4, 23'h000000, c0);
    wait_done("deg_zero", 60);
    check_seq("deg_zero", 23'h000000, 0, 4);

    // Continuous mode, stop together with write_ready while in WAIT.
    clear_log();
    launch(2, 0, 23'h000200, c0);
    wait_writes("stop_wait", 5, 60);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_wait_done", 32'(done), 32'd1);
    check("stop_wait_write", 32'(write), 32'd0);
    repeat (6) tick();
    check_seq("stop_wait", 23'h000200, 2, 5);
    check("stop_wait_busy", 32'(busy), 32'd0);
    check("stop_wait_done_once", 32'(dn_cnt), 32'd1);

    // Continuous mode, stop during WRITE: that write still completes.
    clear_log();
    launch(2, 0, 23'h000200, c0);
    wait_writes("stop_wr", 5, 60);
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("stop_wr", 10);
    repeat (4) tick();
    check_seq("stop_wr", 23'h000200, 2, 6);
    if (wc.size() == 6) check("stop_wr_done_cyc", 32'(dn_cyc - wc[5]), 32'd1);
    check("stop_wr_busy", 32'(busy), 32'd0);

    // Busy lockout: a mid-burst start with new parameters is ignored.
    clear_log();
    launch(2, 8, 23'h000100, c0);
    wait_writes("lock", 3, 30);
    half_period = 16'd1;
    burst_len   = 20'd2;
    amplitude   = 23'h000055;
    start       = 1'b1;
    tick();
    start = 1'b0;
    wait_done("lock", 100);
    check_seq("lock", 23'h000100, 2, 8);
    clear_log();
    launch(1, 2, 23'h000055, c0);
    wait_done("relaunch", 30);
    check_seq("relaunch", 23'h000055, 1, 2);
    check("relaunch_neg", 32'(wq[1]), 32'hFFFFAB);

    // Asynchronous reset mid-burst while write is high.
    clear_log();
    launch(2, 0, 23'h000300, c0);
    wait_writes("rst_mid", 2, 30);
    check("rst_mid_pre_write", 32'(write), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_write", 32'(write), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_data", 32'(writedata_left), 32'd0);
    #3 resetn = 1'b1;
    clear_log();
    repeat (10) tick();
    nw = wq.size();
    check("rst_after_writes", 32'(nw), 32'd0);
    check("rst_after_done", 32'(dn_cnt), 32'd0);
    check("rst_after_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
